// File: rtl/pipelined_ripple_addsub.sv
// Pipelined WIDTH-bit ripple-carry add/subtract with one SLICE-bit ripple per stage
// and a valid/ready handshake. A stalled output freezes the whole pipe, bubbles included.

module pipelined_ripple_addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);
    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int i = 0; i < SLICE; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

module pipelined_ripple_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);
    localparam int STAGES   = WIDTH / SLICE;
    // Staircase storage packed flat: stage k keeps the operand slices still to be
    // added (k+1..STAGES-1) and the result slices already produced (0..k).
    localparam int OP_BITS  = (STAGES > 1) ? SLICE * STAGES * (STAGES - 1) / 2 : 1;
    localparam int SUM_BITS = SLICE * STAGES * (STAGES + 1) / 2;

    logic [WIDTH-1:0]    b_eff;
    logic [OP_BITS-1:0]  x_q, x_d, b_q, b_d;
    logic [SUM_BITS-1:0] s_q, s_d;
    logic [STAGES-1:0]   c_q, c_d;
    logic                ovf_q, ovf_d;
    logic [STAGES:0]     vld_pipe;
    logic [STAGES:1]     vld_q;
    logic                stall;

    assign b_eff    = sub ? ~Y : Y;
    assign stall    = vld_q[STAGES] & ~out_ready;
    assign in_ready = ~stall;
    assign vld_pipe = {vld_q, in_valid & in_ready};

    if (STAGES == 1) begin : g_noops
        assign x_d = '0;
        assign b_d = '0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE-1:0] a, b, s;
        logic             ci, co;

        if (k == 0) begin : g_first
            assign a  = X[SLICE-1:0];
            assign b  = b_eff[SLICE-1:0];
            assign ci = Cin ^ sub;
            assign s_d[SLICE-1:0] = s;
        end else begin : g_rest
            localparam int XOP = SLICE * ((k - 1) * STAGES - (k - 1) * k / 2);
            localparam int SOP = SLICE * (k - 1) * k / 2;
            localparam int SO  = SLICE * k * (k + 1) / 2;
            assign a  = x_q[XOP +: SLICE];
            assign b  = b_q[XOP +: SLICE];
            assign ci = c_q[k-1];
            assign s_d[SO +: (k + 1) * SLICE] = {s, s_q[SOP +: k * SLICE]};
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int XO  = SLICE * (k * STAGES - k * (k + 1) / 2);
            localparam int OPW = WIDTH - (k + 1) * SLICE;
            if (k == 0) begin : g_load
                assign x_d[XO +: OPW] = X[WIDTH-1:SLICE];
                assign b_d[XO +: OPW] = b_eff[WIDTH-1:SLICE];
            end else begin : g_pass
                localparam int XOP = SLICE * ((k - 1) * STAGES - (k - 1) * k / 2);
                assign x_d[XO +: OPW] = x_q[XOP + SLICE +: OPW];
                assign b_d[XO +: OPW] = b_q[XOP + SLICE +: OPW];
            end
        end else begin : g_last
            assign ovf_d = (a[SLICE-1] == b[SLICE-1]) && (s[SLICE-1] != a[SLICE-1]);
        end

        pipelined_ripple_addsub_slice #(.SLICE(SLICE)) u_slice (
            .a  (a),
            .b  (b),
            .ci (ci),
            .s  (s),
            .co (co)
        );
        assign c_d[k] = co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            x_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            vld_q <= vld_pipe[STAGES-1:0];
            x_q   <= x_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = vld_q[STAGES];
    assign S         = s_q[SUM_BITS-WIDTH +: WIDTH];
    assign Cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_ripple_addsub.sv
// Bench for pipelined_ripple_addsub: directed arithmetic vectors, streaming with
// backpressure, bubbles and mid-flight reset, checked against an integer model.

module tb_pipelined_ripple_addsub;
    localparam int LAT = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, Cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [15:0] X = '0, Y = '0;
    logic        in_ready, out_valid, Cout, ovf;
    logic [15:0] S;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    pipelined_ripple_addsub #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .ovf(ovf)
    );

    // {Cout, ovf, S} from plain integer arithmetic on unsigned and signed views.
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic sb);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint c  = ci ? 1 : 0;
        longint sx = x[15] ? ux - 65536 : ux;
        longint sy = y[15] ? uy - 65536 : uy;
        longint r, sr;
        logic   co, ov;
        if (sb) begin
            r  = ux - uy - c;
            sr = sx - sy - c;
            co = (r >= 0);
        end else begin
            r  = ux + uy + c;
            sr = sx + sy + c;
            co = (r > 65535);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {co, ov, 16'(r & 65535)};
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, in_ready, Cout, ovf, S} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state: got ov=%b ir=%b co=%b ovf=%b S=%h want 0 1 0 0 0000",
                     out_valid, in_ready, Cout, ovf, S);
        end
    endtask

    task automatic test_directed();
        logic [15:0] tx [7] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000, 16'h0010, 16'h0000};
        logic [15:0] ty [7] = '{16'h0001, 16'h0001, 16'h0FED, 16'h0007, 16'h0001, 16'h0003, 16'h0000};
        logic        tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [15:0] es [7] = '{16'h0000, 16'h8000, 16'h2222, 16'hFFFE, 16'h7FFF, 16'h000C, 16'hFFFF};
        logic        ec [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eo [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int n;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            X = tx[i]; Y = ty[i]; Cin = tc[i]; sub = ts[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n = 1;
            while (out_valid !== 1'b1 && n < 12) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != LAT) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles want %0d", i, n, LAT);
            end
            checks++;
            if ({Cout, ovf, S} !== {ec[i], eo[i], es[i]}) begin
                errors++;
                $display("FAIL directed[%0d]: got S=%h Cout=%b ovf=%b want S=%h Cout=%b ovf=%b",
                         i, S, Cout, ovf, es[i], ec[i], eo[i]);
            end
        end
        idle(2);
    endtask

    // rnd=0: every cycle offers an op, out_ready low for cycles 6..9.
    // rnd=1: random in_valid and out_ready.
    task automatic test_stream(input int n_ops, input bit rnd, input string tag);
        logic [17:0] q[$];
        logic [17:0] exp_r, held;
        logic [15:0] nx, ny;
        logic        nc, ns, stall_now, exp_ir;
        bit          prev_stall = 0;
        int          issued = 0, rcvd = 0, c = 0;
        nx = 16'($urandom); ny = 16'($urandom);
        nc = 1'($urandom);  ns = 1'($urandom);
        held = '0;
        while ((issued < n_ops || rcvd < n_ops) && c < 400) begin
            @(negedge clk);
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= 6 && c <= 9);
            in_valid  = (issued < n_ops) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            X = nx; Y = ny; Cin = nc; sub = ns;
            #1;
            stall_now = out_valid && !out_ready;
            exp_ir    = rnd ? !stall_now : !(c >= 6 && c <= 9);
            checks++;
            if (in_ready !== exp_ir) begin
                errors++;
                $display("FAIL %s in_ready c=%0d: got %b want %b", tag, c, in_ready, exp_ir);
            end
            if (stall_now && prev_stall) begin
                checks++;
                if ({Cout, ovf, S} !== held) begin
                    errors++;
                    $display("FAIL %s stall_hold c=%0d: got %h want %h", tag, c, {Cout, ovf, S}, held);
                end
            end
            held       = {Cout, ovf, S};
            prev_stall = stall_now;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_result c=%0d: got S=%h want none", tag, c, S);
                end else begin
                    exp_r = q.pop_front();
                    if ({Cout, ovf, S} !== exp_r) begin
                        errors++;
                        $display("FAIL %s result[%0d]: got %h want %h", tag, rcvd, {Cout, ovf, S}, exp_r);
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_op(X, Y, Cin, sub));
                issued++;
                nx = 16'($urandom); ny = 16'($urandom);
                nc = 1'($urandom);  ns = 1'($urandom);
            end
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd != n_ops || issued != n_ops) begin
            errors++;
            $display("FAIL %s count: got %0d results of %0d issued want %0d", tag, rcvd, issued, n_ops);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s duplicate: got out_valid=%b want 0", tag, out_valid);
            end
        end
    endtask

    task automatic test_bubbles();
        logic [17:0] q[$];
        logic [17:0] exp_r;
        bit          pat [18];
        logic        exp_ov;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            in_valid = (c < 10) && (c % 2 == 0);
            X = 16'($urandom); Y = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
            #1;
            pat[c] = in_valid;
            if (in_valid) q.push_back(ref_op(X, Y, Cin, sub));
            exp_ov = (c >= LAT) ? pat[c-LAT] : 1'b0;
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL bubble_valid c=%0d: got %b want %b", c, out_valid, exp_ov);
            end
            if (out_valid && q.size() > 0) begin
                exp_r = q.pop_front();
                checks++;
                if ({Cout, ovf, S} !== exp_r) begin
                    errors++;
                    $display("FAIL bubble_result c=%0d: got %h want %h", c, {Cout, ovf, S}, exp_r);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int n;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            X = 16'($urandom); Y = 16'($urandom); Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_inflight: got out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, Cout, ovf, S} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL rst_mid_async: got ov=%b ir=%b co=%b ovf=%b S=%h want 0 1 0 0 0000",
                     out_valid, in_ready, Cout, ovf, S);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale[%0d]: got out_valid=%b want 0", i, out_valid);
            end
        end
        X = 16'h0001; Y = 16'h0001; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != LAT || S !== 16'h0002 || Cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fresh: got lat=%0d S=%h co=%b ovf=%b want lat=%0d S=0002 co=0 ovf=0",
                     n, S, Cout, ovf, LAT);
        end
        idle(2);
    endtask

    initial begin
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        test_directed();
        test_stream(8, 1'b0, "stream_bp");
        test_bubbles();
        test_stream(60, 1'b1, "stream_rnd");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_ripple_addsub.md
Name: pipelined_ripple_addsub

Overview:
- Parametrised, pipelined successor to the 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES slices of SLICE bits. Each slice is a ripple of full adders, with a register boundary after each slice.
- Carries a valid/ready handshake with full backpressure, so one operation is accepted per cycle at full clock rate.
- Sits in the datapath library as the standard wide adder for ALU and accumulator blocks.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits per pipeline slice; STAGES = WIDTH/SLICE, must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- S  output  WIDTH  sum/difference.
- Cout  output  1  carry-out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- One clock, clk; reset rst_n asynchronous, active-low.
- While rst_n = 0, all pipeline valid bits clear, and S, Cout, ovf = 0, out_valid = 0.
- in_ready is combinational and follows the stall rule below; it is 1 in reset, since the pipeline is empty.
- Deassertion of rst_n is synchronised externally; the first transfer can be accepted on the first rising edge after release.

Arithmetic:
- Effective B = sub ? ~Y : Y.
- Carry into slice 0 = Cin XOR sub.
- Add: S = X + Y + Cin.
- Sub: S = X − Y − Cin.
- Result is mod 2^WIDTH.
- Cout = carry out of bit WIDTH−1.
- ovf = (X[MSB] == B[MSB]) && (S[MSB] != X[MSB]), using effective B.

Pipeline:
- Staircase structure. Stage k (0..STAGES−1) adds slice k of X and B with the registered carry from stage k−1.
- Lower result slices are delayed forward.
- Upper operand slices are delayed until their stage.
- sub-derived B is computed at the input, so no mode bit travels in the pipe beyond B.
- Latency = STAGES cycles from the accepting edge to out_valid; 4 at the defaults.
- Throughput is one operation per cycle when out_ready = 1.

Handshake and stall:
- Transfer in when in_valid && in_ready.
- Transfer out when out_valid && out_ready.
- stall = out_valid && !out_ready.
- in_ready = !stall.
- On stall, every pipeline register holds, including valid bits; bubbles are not compressed.
- S, Cout and ovf stay stable while out_valid = 1 and out_ready = 0.
- in_valid = 0 while in_ready = 1 inserts a bubble; the valid bit propagates as 0.
- Data registers of bubble slots may hold don't-care values, but S, Cout and ovf are only meaningful when out_valid = 1.
- Inputs sampled while in_ready = 0 are ignored; the source must hold them.

Boundary conditions:
- Simultaneous output transfer and input acceptance in the same cycle is legal; there is no lost or duplicated item.
- STAGES = 1 (SLICE = WIDTH) degenerates to a single registered ripple adder with latency 1.
- Reset asserted mid-operation discards all in-flight results; out_valid drops asynchronously.
- Carry across slice boundaries must be exact: a full-width carry ripple, e.g. 0xFFFF + 1, propagates through every stage.

Test Plan:
- Add wrap (WIDTH=16, SLICE=4): X=0xFFFF, Y=0x0001, Cin=0, sub=0 → 4 cycles later S=0x0000, Cout=1, ovf=0.
- Signed overflow add: X=0x7FFF, Y=0x0001, Cin=0 → S=0x8000, Cout=0, ovf=1. Also X=0x1234, Y=0x0FED, Cin=1 → S=0x2222, Cout=0, ovf=0.
- Subtract: X=0x0005, Y=0x0007, sub=1, Cin=0 → S=0xFFFE, Cout=0, ovf=0. Also X=0x8000, Y=0x0001, sub=1 → S=0x7FFF, Cout=1, ovf=1. Also X=0x0010, Y=0x0003, sub=1, Cin=1 → S=0x000C, Cout=1.
- Streaming with backpressure:
  - Issue 8 back-to-back random ops, with out_ready low for cycles 6–9.
  - Required: in_ready low exactly while out_valid && !out_ready; S held stable during the stall.
  - Required: all 8 results in order and matching the reference model; no drops or duplicates.
- Bubbles: alternate in_valid 1/0 for 10 cycles → out_valid pattern is the input pattern delayed by 4 cycles.
- Reset mid-operation: 3 ops in flight, pull rst_n low between clock edges.
  - Required: out_valid=0 and S=0 immediately.
  - Required: after release, no stale results emerge, and a fresh op 0x0001+0x0001 → S=0x0002 at latency 4.
